// File: rtl/sprite_vram_responder.sv
// sprite_vram_responder: serves sprite-renderer word fetches from the shared VRAM read port,
// yielding to the CPU and discarding data for requests the renderer abandons.
module sprite_vram_responder #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spr_strobe,
  input  logic [14:0] spr_addr,
  output logic        spr_ack,
  output logic [31:0] spr_rddata,
  input  logic        cpu_busy,
  output logic [14:0] vram_addr,
  output logic        vram_rden,
  input  logic [31:0] vram_rddata,
  output logic [7:0]  abort_count,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);
  state_t      state;
  logic [14:0] addr_r;
  logic [2:0]  lat_cnt;
  logic [31:0] rddata_r;
  logic        ack_r;
  logic [7:0]  abort_inc;
  logic [2:0]  lat_dec;
  assign abort_inc  = abort_count + {7'd0, abort_count != 8'hff};
  assign lat_dec    = lat_cnt == 3'd0 ? 3'd0 : lat_cnt - 3'd1;
  assign spr_ack    = ack_r;
  assign spr_rddata = rddata_r;
  assign vram_addr  = addr_r;
  // an abandoned request in ISSUE must never reach the VRAM port
  assign vram_rden  = state == ISSUE && spr_strobe && !cpu_busy;
  assign busy       = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_r      <= '0;
      lat_cnt     <= '0;
      rddata_r    <= '0;
      ack_r       <= 1'b0;
      abort_count <= '0;
    end else begin
      ack_r <= 1'b0;
      case (state)
        IDLE: if (spr_strobe && !ack_r) begin
          addr_r <= spr_addr;
          state  <= ISSUE;
        end
        ISSUE: if (!spr_strobe) begin
          abort_count <= abort_inc;
          state       <= IDLE;
        end else if (!cpu_busy) begin
          lat_cnt <= LAT_M1;
          state   <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_dec;
          if (!spr_strobe) begin
            abort_count <= abort_inc;
            state       <= lat_cnt == 3'd0 ? IDLE : DRAIN;
          end else if (lat_cnt == 3'd0) begin
            rddata_r <= vram_rddata;
            ack_r    <= 1'b1;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          lat_cnt <= lat_dec;
          state   <= lat_cnt == 3'd0 ? IDLE : DRAIN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_vram_responder.sv
// tb_sprite_vram_responder: directed checks of fetch timing, contention, aborts, reset and
// abort-count saturation against a 2-cycle VRAM model.
module tb_sprite_vram_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spr_strobe = 1'b0;
  logic [14:0] spr_addr = '0;
  logic        spr_ack;
  logic [31:0] spr_rddata;
  logic        cpu_busy = 1'b0;
  logic [14:0] vram_addr;
  logic        vram_rden;
  logic [31:0] vram_rddata;
  logic [7:0]  abort_count;
  logic        busy;
  int checks = 0;
  int failures = 0;

  sprite_vram_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .spr_strobe(spr_strobe), .spr_addr(spr_addr),
    .spr_ack(spr_ack), .spr_rddata(spr_rddata), .cpu_busy(cpu_busy),
    .vram_addr(vram_addr), .vram_rden(vram_rden), .vram_rddata(vram_rddata),
    .abort_count(abort_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [14:0] a);
    return a == 15'h1234 ? 32'hdeadbeef : {1'b0, a, 1'b1, ~a};
  endfunction

  // two-stage VRAM read pipe; data is garbage unless a read is landing this cycle
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [14:0] a0 = '0, a1 = '0;
  always @(posedge clk) begin
    v0 <= vram_rden;
    a0 <= vram_addr;
    v1 <= v0;
    a1 <= a0;
  end
  assign vram_rddata = v1 ? mem(a1) : 32'h0bad0bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    spr_strobe = 1'b0;
    cpu_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic seq(input string tag, input int n, input logic [15:0] stb, input logic [15:0] cb,
                     input logic [15:0] rd, input logic [15:0] ak, input logic [15:0] bz,
                     input logic [14:0] addr0, input logic [14:0] addr1, input int sw,
                     input logic [31:0] dat);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spr_strobe = stb[i];
      cpu_busy = cb[i];
      spr_addr = i < sw ? addr0 : addr1;
      #1;
      chk($sformatf("%s_rden%0d", tag, i), 32'(vram_rden), 32'(rd[i]));
      chk($sformatf("%s_ack%0d", tag, i), 32'(spr_ack), 32'(ak[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(bz[i]));
      if (rd[i]) chk($sformatf("%s_addr%0d", tag, i), 32'(vram_addr), 32'(i < sw ? addr0 : addr1));
      if (ak[i]) chk($sformatf("%s_data%0d", tag, i), spr_rddata, dat);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", 32'(spr_ack), 32'd0);
    chk("rst_rddata", spr_rddata, 32'd0);
    chk("rst_rden", 32'(vram_rden), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_abort", 32'(abort_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // single fetch: rden at T+1, ack at T+4
    seq("single", 7, 16'b0001111, 16'b0, 16'b0000010, 16'b0010000, 16'b0001110,
        15'h1234, 15'h1234, 7, 32'hdeadbeef);
    chk("single_hold", spr_rddata, 32'hdeadbeef);

    // cpu_busy for 3 cycles from T+1: rden at T+4, ack at T+7
    seq("contend", 10, 16'b0001111111, 16'b0000001110, 16'b0000010000, 16'b0010000000,
        16'b0001111110, 15'h0abc, 15'h0abc, 10, mem(15'h0abc));
    chk("contend_abort", 32'(abort_count), 32'd0);

    // abort in ISSUE under contention
    do_reset();
    seq("abort_issue", 5, 16'b00001, 16'b00010, 16'b0, 16'b0, 16'b00010,
        15'h0555, 15'h0555, 5, 32'd0);
    chk("abort_issue_cnt", 32'(abort_count), 32'd1);

    // abort in WAIT, re-request during DRAIN is taken only once back in IDLE
    do_reset();
    seq("abort_wait", 10, 16'b0011111011, 16'b0, 16'b0000100010, 16'b0100000000,
        16'b0011101110, 15'h1111, 15'h0020, 3, mem(15'h0020));
    chk("abort_wait_cnt", 32'(abort_count), 32'd1);

    // throughput: 64 back-to-back fetches, one every LATENCY+3 cycles
    do_reset();
    begin
      int nack = 0, nrd = 0, last = 0;
      logic [14:0] a = 15'h0100;
      for (int c = 0; c < 600 && nack < 64; c++) begin
        @(negedge clk);
        spr_strobe = 1'b1;
        spr_addr = a;
        cpu_busy = 1'b0;
        #1;
        if (vram_rden) nrd++;
        if (spr_ack) begin
          spr_strobe = 1'b0;
          chk($sformatf("tp_data%0d", nack), spr_rddata, mem(a));
          if (nack > 0) chk($sformatf("tp_gap%0d", nack), 32'(c - last), 32'd5);
          last = c;
          nack++;
          a = a + 15'h0101;
        end
      end
      @(negedge clk);
      spr_strobe = 1'b0;
      #1;
      chk("tp_ack_len", 32'(spr_ack), 32'd0);
      chk("tp_acks", 32'(nack), 32'd64);
      chk("tp_reads", 32'(nrd), 32'd64);
      chk("tp_abort", 32'(abort_count), 32'd0);
    end

    // asynchronous reset while in WAIT, then the returning read must not ack
    seq("pre_rst", 3, 16'b111, 16'b0, 16'b010, 16'b0, 16'b110, 15'h0777, 15'h0777, 3, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(spr_ack), 32'd0);
    chk("arst_rddata", spr_rddata, 32'd0);
    chk("arst_addr", 32'(vram_addr), 32'd0);
    chk("arst_rden", 32'(vram_rden), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spr_strobe = 1'b0;
    seq("post_rst", 4, 16'b0, 16'b0, 16'b0, 16'b0, 16'b0, 15'h0, 15'h0, 4, 32'd0);
    chk("post_rst_rddata", spr_rddata, 32'd0);

    // 300 aborts in ISSUE: counter saturates at 255
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      spr_strobe = 1'b1;
      @(negedge clk);
      spr_strobe = 1'b0;
      @(negedge clk);
      #1;
      if (k == 100 || k == 255 || k == 300)
        chk($sformatf("sat%0d", k), 32'(abort_count), k == 300 ? 32'd255 : 32'(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
